// File: rtl/game_pkg.sv
// Shared definitions for the arcade game controller and its object controllers.
package game_pkg;

  localparam int unsigned N_OBJ_DEF   = 4;
  localparam int unsigned SCORE_W_DEF = 8;
  localparam int unsigned STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_GRANT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/game_scheduler_pass_sequencer.sv
// Per-frame plotter arbitration: snapshots obj_en, walks enabled objects in index order.
// Optional grant watchdog when GAME_SCHED_TIMEOUT_EN is defined.
module pass_sequencer
  import game_pkg::*;
#(
  parameter int unsigned N_OBJ       = N_OBJ_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [N_OBJ-1:0]           obj_en,
  input  logic [N_OBJ-1:0]           obj_done,
  output logic [N_OBJ-1:0]           obj_grant,
  output logic [$clog2(N_OBJ)-1:0]   obj_id,
  output logic                       busy,
  output logic                       pass_done,
  output logic                       timeout_err
`ifdef GAME_SCHED_TIMEOUT_EN
  ,
  input  logic                       clear_err
`endif
);

  localparam int unsigned ID_W = $clog2(N_OBJ);
  localparam logic [N_OBJ-1:0] ONE = N_OBJ'(1);

  if (N_OBJ < 2 || N_OBJ > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("pass_sequencer: N_OBJ must be 2..16 and TIMEOUT_CYC at least 1");
  end

  seq_state_e        state_q;
  logic [N_OBJ-1:0]  en_q;
  logic [N_OBJ-1:0]  grant_q;
  logic [ID_W-1:0]   id_q;
  logic              pass_done_q;

  logic              first_hit_c;
  logic [ID_W-1:0]   first_idx_c;
  logic              next_hit_c;
  logic [ID_W-1:0]   next_idx_c;
  logic              done_hit_c;
  logic              wd_fire_c;
  logic              advance_c;

  // Lowest enabled index at pass start, and lowest snapshot index above the current grant.
  always_comb begin
    first_hit_c = 1'b0;
    first_idx_c = '0;
    next_hit_c  = 1'b0;
    next_idx_c  = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (obj_en[i]) begin
        first_hit_c = 1'b1;
        first_idx_c = ID_W'(i);
      end
      if (en_q[i] && (i > int'(id_q))) begin
        next_hit_c = 1'b1;
        next_idx_c = ID_W'(i);
      end
    end
  end

  assign done_hit_c = (state_q == SEQ_GRANT) && obj_done[id_q];
  assign advance_c  = done_hit_c || wd_fire_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= SEQ_IDLE;
      en_q        <= '0;
      grant_q     <= '0;
      id_q        <= '0;
      pass_done_q <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            en_q <= obj_en;
            if (first_hit_c) begin
              state_q <= SEQ_GRANT;
              grant_q <= ONE << first_idx_c;
              id_q    <= first_idx_c;
            end else begin
              pass_done_q <= 1'b1;
            end
          end
        end
        SEQ_GRANT: begin
          if (advance_c) begin
            if (next_hit_c) begin
              grant_q <= ONE << next_idx_c;
              id_q    <= next_idx_c;
            end else begin
              state_q     <= SEQ_IDLE;
              grant_q     <= '0;
              id_q        <= '0;
              pass_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= SEQ_IDLE;
          grant_q <= '0;
          id_q    <= '0;
        end
      endcase
    end
  end

`ifdef GAME_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            terr_q;

  assign wd_fire_c = (state_q == SEQ_GRANT) && !done_hit_c &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Cycles spent on the current grant; restarts whenever the grant changes or drops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_q <= '0;
    end else if ((state_q != SEQ_GRANT) || advance_c) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      terr_q <= 1'b0;
    end else if (clear_err) begin
      terr_q <= 1'b0;
    end else if (wd_fire_c) begin
      terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  assign wd_fire_c   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign obj_grant = grant_q;
  assign obj_id    = id_q;
  assign busy      = (state_q == SEQ_GRANT);
  assign pass_done = pass_done_q;

endmodule

// File: rtl/game_scheduler.sv
// Game phase FSM, collision latch, score and overrun tracking around the pass sequencer.
// Define GAME_SCHED_TIMEOUT_EN to build the per-grant watchdog.
module game_scheduler
  import game_pkg::*;
#(
  parameter int unsigned N_OBJ       = N_OBJ_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      go,
  input  logic                      frame_tick,
  input  logic                      collision,
  input  logic                      score_inc,
  input  logic [N_OBJ-1:0]          obj_en,
  input  logic [N_OBJ-1:0]          obj_done,
  output logic [N_OBJ-1:0]          obj_grant,
  output logic [$clog2(N_OBJ)-1:0]  obj_id,
  output logic [STATE_W-1:0]        game_state,
  output logic                      pass_done,
  output logic [SCORE_W-1:0]        score,
  output logic                      frame_overrun,
  output logic                      timeout_err
);

  game_state_e        state_q;
  logic               coll_q;
  logic [SCORE_W-1:0] score_q;
  logic               overrun_q;

  logic               busy;
  logic               seq_pass_done;
  logic               in_play_c;
  logic               enter_play_c;
  logic               start_c;

  assign in_play_c    = (state_q == ST_PLAY);
  assign enter_play_c = (state_q == ST_IDLE) && go;
  // A tick is only accepted when the sequencer is fully idle, including its pass_done cycle.
  assign start_c      = frame_tick && in_play_c && !coll_q && !busy && !seq_pass_done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (go) state_q <= ST_PLAY;
        ST_PLAY: if (coll_q && !busy) state_q <= ST_OVER;
        ST_OVER: if (go) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      coll_q    <= 1'b0;
      score_q   <= '0;
      overrun_q <= 1'b0;
    end else if (enter_play_c) begin
      coll_q    <= 1'b0;
      score_q   <= '0;
      overrun_q <= 1'b0;
    end else if (in_play_c) begin
      if (collision) coll_q <= 1'b1;
      if (score_inc && (score_q != {SCORE_W{1'b1}})) score_q <= score_q + SCORE_W'(1);
      if (frame_tick && (busy || seq_pass_done)) overrun_q <= 1'b1;
    end
  end

  pass_sequencer #(
    .N_OBJ       (N_OBJ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_pass_sequencer (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start_c),
    .obj_en      (obj_en),
    .obj_done    (obj_done),
    .obj_grant   (obj_grant),
    .obj_id      (obj_id),
    .busy        (busy),
    .pass_done   (seq_pass_done),
    .timeout_err (timeout_err)
`ifdef GAME_SCHED_TIMEOUT_EN
    ,
    .clear_err   (enter_play_c)
`endif
  );

  assign game_state    = state_q;
  assign pass_done     = seq_pass_done;
  assign score         = score_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_game_scheduler.sv
// Scoreboard bench for game_scheduler: expected grant/pass_done events are queued by the
// stimulus and popped by an independent monitor; state, score and flags are checked directly.
module tb_game_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          resetn;
  logic          go;
  logic          frame_tick;
  logic          collision;
  logic          score_inc;
  logic [N-1:0]  obj_en;
  logic [N-1:0]  obj_done;
  logic [N-1:0]  obj_grant;
  logic [1:0]    obj_id;
  logic [1:0]    game_state;
  logic          pass_done;
  logic [SW-1:0] score;
  logic          frame_overrun;
  logic          timeout_err;

  game_scheduler #(
    .N_OBJ       (N),
    .SCORE_W     (SW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .go            (go),
    .frame_tick    (frame_tick),
    .collision     (collision),
    .score_inc     (score_inc),
    .obj_en        (obj_en),
    .obj_done      (obj_done),
    .obj_grant     (obj_grant),
    .obj_id        (obj_id),
    .game_state    (game_state),
    .pass_done     (pass_done),
    .score         (score),
    .frame_overrun (frame_overrun),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    bit is_done;
    int id;
    int cyc;
  } ev_t;

  ev_t    exp_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  int     cyc    = 0;
  int     lat[N];
  logic [N-1:0] spur;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit is_done, input int id, input int at);
    ev_t e;
    e.is_done = is_done;
    e.id      = id;
    e.cyc     = at;
    exp_q.push_back(e);
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  // Object model: done rises once a grant has been held lat[i] cycles (0 = never).
  initial begin
    logic [N-1:0] prev;
    int held;
    int idx;
    logic [N-1:0] d;
    obj_done = '0;
    prev = '0;
    held = 0;
    forever begin
      @(negedge clk);
      if (obj_grant != '0 && obj_grant == prev) held++;
      else held = (obj_grant != '0) ? 1 : 0;
      prev = obj_grant;
      d = '0;
      idx = 0;
      for (int i = 0; i < N; i++) if (obj_grant[i]) idx = i;
      if (obj_grant != '0 && lat[idx] != 0 && held >= lat[idx]) d = obj_grant;
      obj_done = d | spur;
    end
  end

  // Monitor: every new grant and every pass_done pulse must match the head of the queue.
  task automatic observe(input bit is_done, input int id);
    ev_t e;
    logic [N-1:0] one;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got %s id=%0d at cycle %0d, expected nothing",
               is_done ? "pass_done" : "grant", id, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(is_done), 32'(e.is_done));
      check("event_cycle", 32'(cyc), 32'(e.cyc));
      if (!e.is_done) begin
        one = N'(1) << e.id;
        check("grant_id", 32'(id), 32'(e.id));
        check("grant_onehot", 32'(obj_grant), 32'(one));
      end
    end
  endtask

  initial begin
    logic [N-1:0] mon_prev;
    mon_prev = '0;
    forever begin
      @(negedge clk);
      if (pass_done === 1'b1) observe(1'b1, 0);
      if (obj_grant !== 'x && obj_grant != '0 && obj_grant != mon_prev) observe(1'b0, int'(obj_id));
      mon_prev = obj_grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    int c;
    resetn = 1'b0; go = 1'b0; frame_tick = 1'b0; collision = 1'b0; score_inc = 1'b0;
    obj_en = '0; spur = '0;
    for (int i = 0; i < N; i++) lat[i] = 3;
    step(3);
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_grant", 32'(obj_grant), 32'd0);
    check("rst_id", 32'(obj_id), 32'd0);
    check("rst_pass_done", 32'(pass_done), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_overrun", 32'(frame_overrun), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    step(1);

    go_pulse();
    check("idle_to_play", 32'(game_state), 32'd1);

    // Enabled 0,1,3 with 3-cycle done; a stray done on disabled object 2 must be ignored.
    obj_en = 4'b1011; spur = 4'b0100; c = cyc;
    push(0, 0, c + 1); push(0, 1, c + 4); push(0, 3, c + 7); push(1, 0, c + 10);
    tick_pulse();
    step(12);
    spur = '0;
    check("pass1_overrun", 32'(frame_overrun), 32'd0);
    check("pass1_state", 32'(game_state), 32'd1);

    // Empty snapshot: pass_done the cycle after the tick, no grant.
    obj_en = 4'b0000; c = cyc;
    push(1, 0, c + 1);
    tick_pulse();
    step(3);

    score_inc = 1'b1;
    step(5);
    score_inc = 1'b0;
    check("score_saturate", 32'(score), 32'd3);

    // Ticks mid-pass and on the pass_done cycle are dropped.
    obj_en = 4'b0001; lat[0] = 6; c = cyc;
    push(0, 0, c + 1); push(1, 0, c + 7);
    tick_pulse();
    step(1);
    tick_pulse();
    check("overrun_set", 32'(frame_overrun), 32'd1);
    step(4);
    check("overrun_pd_cycle", 32'(pass_done), 32'd1);
    tick_pulse();
    step(8);
    lat[0] = 3;

    // Collision while object 1 is granted: pass completes, then OVER.
    obj_en = 4'b1011; c = cyc;
    push(0, 0, c + 1); push(0, 1, c + 4); push(0, 3, c + 7); push(1, 0, c + 10);
    tick_pulse();
    step(4);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    step(4);
    check("coll_still_play", 32'(game_state), 32'd1);
    step(1);
    check("coll_over", 32'(game_state), 32'd2);
    tick_pulse();
    step(4);
    check("over_score_hold", 32'(score), 32'd3);
    check("over_overrun_hold", 32'(frame_overrun), 32'd1);

    go_pulse();
    check("over_to_idle", 32'(game_state), 32'd0);
    check("idle_score_hold", 32'(score), 32'd3);
    go_pulse();
    check("restart_play", 32'(game_state), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    check("restart_overrun", 32'(frame_overrun), 32'd0);
    check("restart_timeout", 32'(timeout_err), 32'd0);

    obj_en = 4'b0100; c = cyc;
    push(0, 2, c + 1); push(1, 0, c + 4);
    tick_pulse();
    step(5);

`ifdef GAME_SCHED_TIMEOUT_EN
    // Object 0 never finishes: watchdog forces the move to object 1 after 8 cycles.
    lat[0] = 0; lat[1] = 3; obj_en = 4'b0011; c = cyc;
    push(0, 0, c + 1); push(0, 1, c + 9); push(1, 0, c + 12);
    tick_pulse();
    step(13);
    check("timeout_flag", 32'(timeout_err), 32'd1);
`else
    // Without the watchdog a silent object keeps the grant indefinitely.
    lat[0] = 0; obj_en = 4'b0001; c = cyc;
    push(0, 0, c + 1);
    tick_pulse();
    step(20);
    check("hold_grant", 32'(obj_grant), 32'd1);
    check("no_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    lat[0] = 1;
    push(1, 0, cyc + 1);
    step(4);
`endif

    step(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_scheduler.md
# game_scheduler

Parametrised top-level game controller for the VGA arcade datapath. It sequences a game through idle, play and game-over phases. Once per frame tick it time-multiplexes N object controllers (bird, walls, background, score sprite, …) onto the single shared plotter using a one-hot grant/done handshake. It replaces the fixed two-object wall/bird toggling with a configurable object count, per-object enables, collision-driven game over, a score counter and overrun detection.

## Interface
Parameters:
- N_OBJ, 4: number of object controllers; 2..16.
- SCORE_W, 8: score counter width.
- TIMEOUT_CYC, 1024: grant watchdog limit in cycles. Used only with the timeout feature.

Ports:
- clk  in  1  system clock; one clock domain.
- resetn  in  1  synchronous, active-low reset.
- go  in  1  start/restart request, one-cycle pulse (debounced upstream).
- frame_tick  in  1  one-cycle pulse per frame.
- collision  in  1  collision flag from the datapath.
- score_inc  in  1  one-cycle pulse, +1 score.
- obj_en  in  N_OBJ  per-object enable; sampled at pass start.
- obj_done  in  N_OBJ  object i finished its update/draw.
- obj_grant  out  N_OBJ  one-hot (or zero) plotter grant.
- obj_id  out  $clog2(N_OBJ)  index of the granted object; 0 when no grant.
- game_state  out  2  IDLE=0, PLAY=1, OVER=2.
- pass_done  out  1  one-cycle pulse when a frame pass completes.
- score  out  SCORE_W  current score.
- frame_overrun  out  1  sticky: a frame_tick arrived mid-pass.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- Game FSM:
  - IDLE→PLAY on go. Entering PLAY clears score, collision latch, frame_overrun and timeout_err.
  - PLAY→OVER when the collision latch is set and no pass is active. If a pass is active, the transition waits for it to finish.
  - OVER→IDLE on go.
  - go is ignored in PLAY. collision is ignored outside PLAY.
- Collision latch: set on any cycle in PLAY with collision=1. It stays set until the next game start.
- Pass sequencer (active only in PLAY):
  - A frame_tick while idle starts a pass. obj_en is snapshotted at that point.
  - The granted object is the lowest enabled index. Disabled objects are skipped with zero extra cycles.
  - Grant i is held until obj_done[i]=1 is sampled while it is granted.
  - On that cycle the grant moves to the next enabled index above i in the following cycle, with no idle gap. If no such index exists, the pass ends: obj_grant=0 and pass_done pulses.
  - obj_done bits for ungranted objects are ignored.
  - No new pass starts once the collision latch is set.
- frame_tick during an active pass, or on the pass_done cycle: the tick is dropped and frame_overrun is set.
- Score: in PLAY, score_inc adds 1 and saturates at 2^SCORE_W−1. Score holds in OVER and IDLE.

## Timing
- Reset (resetn=0 at an edge) forces: game_state=IDLE, obj_grant=0, obj_id=0, pass_done=0, score=0, frame_overrun=0, timeout_err=0, collision latch=0, pass idle.
- Reset mid-pass drops the grant on the next edge.
- All outputs are registered.
- go at edge t → game_state=PLAY at t+1.
- frame_tick at t → first grant at t+1.
  - If the snapshot of obj_en is all zero: no grant, and pass_done at t+1.
- obj_done[i] sampled at t → next grant, or pass_done, at t+1.
- Pass of k enabled objects with done latencies d_j: length is Σd_j cycles from first grant to pass_done.
- A done and a collision on the same cycle: the pass completes normally. game_state=OVER in the cycle after pass_done.

## Configuration
- GAME_SCHED_TIMEOUT_EN defined:
  - A watchdog counter restarts on every new grant.
  - If obj_done is not seen after TIMEOUT_CYC cycles of the same grant, the sequencer advances as if done arrived, and sets timeout_err.
- Not defined: no counter is built, timeout_err is tied to 0, and a grant waits indefinitely.

## Structure
- Shared package game_pkg: game_state encoding (IDLE/PLAY/OVER) and the default N_OBJ/SCORE_W constants used by the object controllers.
- One sub-module, pass_sequencer, holds the obj_en snapshot, the next-enabled-index priority search, grant/done handling and the optional watchdog.
- game_scheduler holds the game FSM, collision latch, score and overrun logic.

## Test plan
- Reset, go, frame_tick with obj_en=4'b1011 and each done 3 cycles after its grant → grants 0,1,3 in order, no gap cycles; pass_done 9 cycles after the first grant.
- obj_en=0, frame_tick in PLAY → pass_done at t+1, obj_grant never nonzero.
- Collision asserted mid-pass while object 1 is granted → objects 1 and 3 finish, pass_done pulses, OVER next cycle; later frame_ticks produce no grants.
- SCORE_W=2, five score_inc pulses in PLAY → score=3. A go in OVER then another go → score=0 in PLAY.
- frame_tick while object 0 is still granted → frame_overrun=1, and exactly one pass completes.
- With GAME_SCHED_TIMEOUT_EN, TIMEOUT_CYC=8, object 0 never asserts done → grant moves to the next object after 8 cycles, timeout_err=1.
